// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty levels and sticky over/underflow flags; SYNC_FIFO_FWFT_EN selects fall-through reads.
// Latency: 1 cycle registered read (0 with SYNC_FIFO_FWFT_EN); count and flags update on the same edge as the pointers.
// Backpressure: writes while full and reads while empty are dropped and raise the sticky error flags.
module sync_fifo_flags #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 4,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_wr_en,
  input  logic [DATA_WIDTH-1:0]      i_wr_data,
  input  logic                       i_rd_en,
  input  logic                       i_clr_err,
  output logic [DATA_WIDTH-1:0]      o_rd_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_almost_full,
  output logic                       o_almost_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow,
  output logic                       o_underflow
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam int CW        = PTR_WIDTH + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);
  localparam logic [PTR_WIDTH:0] PTR_ONE = (PTR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH:0]    wr_ptr;
  logic [PTR_WIDTH:0]    rd_ptr;
  logic [CW-1:0]         count_next;
  logic                  wr_acc;
  logic                  rd_acc;

  assign wr_acc = i_wr_en & ~o_full;
  assign rd_acc = i_rd_en & ~o_empty;

  always_comb begin
    count_next = o_count;
    if (wr_acc && !rd_acc) begin
      count_next = o_count + CNT_ONE;
    end else if (rd_acc && !wr_acc) begin
      count_next = o_count - CNT_ONE;
    end
  end

  // Flags come from count_next so they move on the same edge as o_count.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      o_count        <= '0;
      o_full         <= 1'b0;
      o_empty        <= 1'b1;
      o_almost_full  <= 1'b0;
      o_almost_empty <= 1'b1;
      o_overflow     <= 1'b0;
      o_underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      o_count        <= count_next;
      o_full         <= (count_next == CNT_FULL);
      o_empty        <= (count_next == '0);
      o_almost_full  <= (count_next >= CNT_AF);
      o_almost_empty <= (count_next <= CNT_AE);
      o_overflow     <= (i_wr_en & o_full)  | (o_overflow  & ~i_clr_err);
      o_underflow    <= (i_rd_en & o_empty) | (o_underflow & ~i_clr_err);
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_acc) mem[wr_ptr[PTR_WIDTH-1:0]] <= i_wr_data;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign o_rd_data = mem[rd_ptr[PTR_WIDTH-1:0]];
`else
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_rd_data <= '0;
    end else if (rd_acc) begin
      o_rd_data <= mem[rd_ptr[PTR_WIDTH-1:0]];
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Randomised and directed bench for sync_fifo_flags (DEPTH=8, DATA_WIDTH=4, AF=6, AE=2), against a queue model.
module tb_sync_fifo_flags;

  localparam int DEPTH = 8;
  localparam int DW    = 4;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk;
  logic          rstn;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic          clr_err;
  logic [DW-1:0] rd_data;
  logic          full, empty, almost_full, almost_empty;
  logic [3:0]    count;
  logic          overflow, underflow;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of stored words plus the last popped word and sticky flags.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd;
  bit            m_ovf, m_unf;

  sync_fifo_flags #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .i_rd_en(rd_en), .i_clr_err(clr_err), .o_rd_data(rd_data),
    .o_full(full), .o_empty(empty), .o_almost_full(almost_full),
    .o_almost_empty(almost_empty), .o_count(count),
    .o_overflow(overflow), .o_underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_rd  = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Drive one cycle, advance the model on the edge, return #1 after it.
  task automatic cyc(input bit wr, input logic [DW-1:0] wd, input bit rd, input bit clr);
    bit was_full, was_empty;
    wr_en = wr; wr_data = wd; rd_en = rd; clr_err = clr;
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (rd && !was_empty) m_rd = q.pop_front();
    if (wr && !was_full)  q.push_back(wd);
    m_ovf = (wr && was_full)  || (m_ovf && !clr);
    m_unf = (rd && was_empty) || (m_unf && !clr);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = '0;
    model_reset();
    #12;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = '0;
    model_reset();
    #12;
    checks++;
    if ({empty, almost_empty, full, almost_full, overflow, underflow} !== 6'b110000 ||
        count !== 4'd0 || rd_data !== 4'd0) begin
      errors++;
      $display("FAIL reset: e=%b ae=%b f=%b af=%b ov=%b un=%b cnt=%0d rd=%h, required 1 1 0 0 0 0 0 0",
               empty, almost_empty, full, almost_full, overflow, underflow, count, rd_data);
    end
    @(negedge clk);
    rstn = 1'b1;
    cyc(0, 0, 0, 0);
    checks++;
    if (empty !== 1'b1 || count !== 4'd0) begin
      errors++;
      $display("FAIL idle_after_reset: empty=%b count=%0d, required 1 0", empty, count);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(1, DW'(i), 0, 0);
      checks++;
      if (count !== 4'(i) || almost_empty !== (i <= AE) || almost_full !== (i >= AF) ||
          full !== (i == DEPTH) || empty !== 1'b0) begin
        errors++;
        $display("FAIL fill_%0d: cnt=%0d ae=%b af=%b f=%b e=%b, required cnt=%0d ae=%b af=%b f=%b e=0",
                 i, count, almost_empty, almost_full, full, empty, i, (i <= AE), (i >= AF), (i == DEPTH));
      end
    end
  endtask

  task automatic test_overflow_drain();
    cyc(1, 4'hF, 0, 0);
    checks++;
    if (overflow !== 1'b1 || count !== 4'd8 || full !== 1'b1) begin
      errors++;
      $display("FAIL overflow: ov=%b cnt=%0d full=%b, required 1 8 1", overflow, count, full);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(0, 0, 1, 0);
      checks++;
      if (rd_data !== DW'(i) || count !== 4'(DEPTH - i)) begin
        errors++;
        $display("FAIL drain_%0d: rd=%h cnt=%0d, required %h %0d", i, rd_data, count, DW'(i), DEPTH - i);
      end
    end
    checks++;
    if (empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL drained_flags: e=%b ae=%b f=%b, required 1 1 0", empty, almost_empty, full);
    end
  endtask

  task automatic test_underflow_clr();
    logic [DW-1:0] held;
    held = rd_data;
    cyc(0, 0, 1, 0);
    checks++;
    if (underflow !== 1'b1 || rd_data !== held || count !== 4'd0) begin
      errors++;
      $display("FAIL underflow: un=%b rd=%h cnt=%0d, required 1 %h 0", underflow, rd_data, count, held);
    end
    cyc(0, 0, 0, 1);
    checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL clr_err: ov=%b un=%b, required 0 0", overflow, underflow);
    end
    // Empty with simultaneous rd/wr: write taken, read rejected, error set wins over clear.
    cyc(1, 4'hA, 1, 1);
    checks++;
    if (underflow !== 1'b1 || count !== 4'd1 || rd_data !== held) begin
      errors++;
      $display("FAIL empty_rdwr: un=%b cnt=%0d rd=%h, required 1 1 %h", underflow, count, rd_data, held);
    end
    cyc(0, 0, 1, 1);
    checks++;
    if (rd_data !== 4'hA || underflow !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL empty_rdwr_pop: rd=%h un=%b e=%b, required a 0 1", rd_data, underflow, empty);
    end
  endtask

  task automatic test_wrap();
    int got;
    got = 0;
    for (int i = 0; i < 3; i++) cyc(1, DW'(i), 0, 0);
    for (int i = 3; i < 20; i++) begin
      cyc(1, DW'(i), 1, 0);
      checks++;
      if (rd_data !== DW'(got) || count !== 4'd3 || overflow !== 1'b0 || underflow !== 1'b0) begin
        errors++;
        $display("FAIL wrap_%0d: rd=%h cnt=%0d ov=%b un=%b, required %h 3 0 0",
                 got, rd_data, count, overflow, underflow, DW'(got));
      end
      got++;
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0);
      checks++;
      if (rd_data !== DW'(got)) begin
        errors++;
        $display("FAIL wrap_tail_%0d: rd=%h, required %h", got, rd_data, DW'(got));
      end
      got++;
    end
  endtask

  task automatic test_full_simul_async_reset();
    logic [DW-1:0] oldest;
    for (int i = 0; i < DEPTH; i++) cyc(1, DW'($urandom_range(0, 15)), 0, 0);
    oldest = q[0];
    cyc(1, 4'h5, 1, 0);
    checks++;
    if (rd_data !== oldest || overflow !== 1'b1 || count !== 4'd7 || full !== 1'b0) begin
      errors++;
      $display("FAIL full_rdwr: rd=%h ov=%b cnt=%0d f=%b, required %h 1 7 0", rd_data, overflow, count, full, oldest);
    end
    cyc(1, 4'h3, 1, 0);
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({empty, almost_empty, full, almost_full, overflow, underflow} !== 6'b110000 ||
        count !== 4'd0 || rd_data !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: e=%b ae=%b f=%b af=%b ov=%b un=%b cnt=%0d rd=%h, required 1 1 0 0 0 0 0 0",
               empty, almost_empty, full, almost_full, overflow, underflow, count, rd_data);
    end
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_random();
    int n;
    n = q.size();
    for (int c = 0; c < 600; c++) begin
      cyc(($urandom_range(0, 99) < 55), DW'($urandom), ($urandom_range(0, 99) < 50),
          ($urandom_range(0, 99) < 8));
      n = q.size();
      checks++;
      if (count !== 4'(n) || full !== (n == DEPTH) || empty !== (n == 0) ||
          almost_full !== (n >= AF) || almost_empty !== (n <= AE) ||
          rd_data !== m_rd || overflow !== m_ovf || underflow !== m_unf) begin
        errors++;
        $display("FAIL random_%0d: cnt=%0d f=%b e=%b af=%b ae=%b rd=%h ov=%b un=%b, required cnt=%0d rd=%h ov=%b un=%b",
                 c, count, full, empty, almost_full, almost_empty, rd_data, overflow, underflow,
                 n, m_rd, m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow_drain();
    test_underflow_clr();
    test_wrap();
    test_full_simul_async_reset();
    test_random();
    apply_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
